uart_rom_loader: RTL
====================

// Module: uart_rom_loader
// PURPOSE
//  UART program loader: receives a framed image on uart_rx_pin while uart_debug_pin is high, packs bytes
//  little-endian into 64-bit words and writes them into the instruction ROM from word 0 upward.
//  Sits upstream of the ROM / core in tinybiriscv_soc_top. Holds the core while loading.
//  Hardware replacement for the bench backdoor rom write() task.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); must be >= 8
//  ROM_AW        14   ROM word-address width; capacity = 2**ROM_AW words of 64 bits
// PORTS
//  clk             in   1       system clock, all logic on rising edge
//  rst_n           in   1       asynchronous active-low reset
//  uart_debug_pin  in   1       loader enable (async pin, 2-flop synchronised internally)
//  uart_rx_pin     in   1       UART RX, 8N1, idle high (2-flop synchronised internally)
//  rom_we_o        out  1       ROM write strobe, one-cycle pulse per word
//  rom_waddr_o     out  ROM_AW  ROM word address
//  rom_wdata_o     out  64      ROM write data, byte 0 of word in [7:0]
//  cpu_hold_o      out  1       core stall/reset request while loading
//  done_o          out  1       image loaded OK (sticky until enable drops)
//  err_o           out  1       framing/length/checksum error (sticky until enable drops)
// BEHAVIOUR
//  Reset: all outputs 0, both FSMs idle, byte counter/word buffer/checksum cleared.
//  UART RX FSM: RX_IDLE -(falling edge)-> RX_START (sample at CLKS_PER_BIT/2; high = glitch, back to RX_IDLE)
//   -> RX_DATA (8 bits LSB first, one sample per CLKS_PER_BIT) -> RX_STOP (stop sample 0 = framing error).
//   Emits byte_valid for one cycle on the stop-bit sample.
//  Frame: 0xA5, LEN[7:0], LEN[15:8], LEN payload bytes, [CSUM]. LEN = payload bytes.
//  Main FSM: IDLE, HDR, LEN0, LEN1, DATA, CSUM, DONE, ERR.
//   IDLE->HDR when synchronised enable rises. HDR: bytes != 0xA5 ignored; 0xA5 -> LEN0 -> LEN1.
//   LEN1: LEN > 8*2**ROM_AW -> ERR; LEN == 0 -> CSUM (or DONE if feature off); else DATA.
//   DATA: byte k goes to lane k%8 of the word buffer; rom_we_o pulses in the cycle after the byte
//    completing a lane-7 word, or after the last payload byte (unused upper lanes = 0x00).
//    rom_waddr_o = k/8; address increments after each write, never wraps (bounded by length check).
//   After last payload byte -> CSUM (or DONE if feature off).
//  DONE/ERR: sticky; further UART bytes ignored; enable low -> IDLE, done_o/err_o clear same cycle.
//  Framing error in any state other than IDLE/DONE/ERR -> ERR. Words already written are not undone.
//  Enable drop in any state: abort to IDLE next cycle, no further rom_we_o, partial word discarded.
//  Enable high again in the same cycle a byte completes: byte belongs to the new frame only if state is HDR.
//  cpu_hold_o = enable_sync & (state != DONE); a load followed by enable low releases the core.
//  rom_wdata_o/rom_waddr_o hold the last written value between strobes.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: trailing CSUM byte expected; CSUM must equal the 8-bit sum mod 256 of
//   LEN0, LEN1 and all payload bytes; match -> DONE, mismatch -> ERR.
//  LOADER_CHECKSUM_EN undefined: no CSUM state or byte; DONE directly after the last payload byte
//   (or after LEN1 when LEN == 0); err_o only from framing or length errors.
// TESTING  (CLKS_PER_BIT=16, ROM_AW=4, LOADER_CHECKSUM_EN defined unless noted)
//  1 Reset mid-frame, rst_n low 3 cycles -> all outputs 0; first word after re-arm written at address 0.
//  2 Enable=1, A5 10 00 00..0F CSUM=0x88 -> rom_we_o x2: addr0 = 0706050403020100,
//    addr1 = 0F0E0D0C0B0A0908; done_o=1, err_o=0.
//  3 A5 05 00 11 22 33 44 55 CSUM=0x04 -> single write addr0 = 0000005544332211, done_o=1.
//  4 Same as 3 with CSUM=0x05 -> the write still occurs, err_o=1, done_o=0; enable low -> err_o=0.
//  5 Stop bit driven 0 on the LEN0 byte -> err_o=1, no writes. LEN=0x0081 (>128) -> err_o=1, no writes.
//  6 Enable dropped after 3 payload bytes -> no rom_we_o, cpu_hold_o=0 next cycle. Feature undefined:
//    A5 08 00 + 8 bytes -> done_o=1 on the last byte, no CSUM byte expected.

Source files
------------

// File: rtl/uart_rom_loader.sv
// UART program loader: receives a framed image (0xA5, LEN16, payload[, CSUM]) and writes it into the
// instruction ROM as little-endian 64-bit words. Define LOADER_CHECKSUM_EN to expect a trailing checksum byte.
module uart_rom_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ROM_AW       = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_debug_pin,
    input  logic              uart_rx_pin,
    output logic              rom_we_o,
    output logic [ROM_AW-1:0] rom_waddr_o,
    output logic [63:0]       rom_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int          BW      = $clog2(CLKS_PER_BIT);
    localparam int          CW      = ROM_AW + 4;
    localparam logic [31:0] MAX_LEN = 32'(8 * (2 ** ROM_AW));

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        LD_IDLE, LD_HDR, LD_LEN0, LD_LEN1, LD_DATA,
`ifdef LOADER_CHECKSUM_EN
        LD_CSUM,
`endif
        LD_DONE, LD_ERR
    } ld_state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_t AFTER_DATA = LD_CSUM;
`else
    localparam ld_state_t AFTER_DATA = LD_DONE;
`endif

    logic [1:0] en_ff, rx_ff;
    logic       en, rx, rx_d;

    // rx synchroniser resets high so reset release never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_ff <= 2'b00;
            rx_ff <= 2'b11;
            rx_d  <= 1'b1;
        end else begin
            en_ff <= {en_ff[0], uart_debug_pin};
            rx_ff <= {rx_ff[0], uart_rx_pin};
            rx_d  <= rx;
        end
    end
    assign en = en_ff[1];
    assign rx = rx_ff[1];

    rx_state_t       rx_st, rx_nxt;
    logic [BW-1:0]   cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            sample, byte_valid, frame_err;

    always_comb begin
        rx_nxt     = rx_st;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        sample     = (rx_st == RX_START) ? (cnt == BW'(CLKS_PER_BIT / 2 - 1))
                                         : (cnt == BW'(CLKS_PER_BIT - 1));
        case (rx_st)
            RX_IDLE:  if (rx_d && !rx) rx_nxt = RX_START;
            RX_START: if (sample) rx_nxt = rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (sample && bit_cnt == 3'd7) rx_nxt = RX_STOP;
            RX_STOP:  if (sample) begin
                rx_nxt     = RX_IDLE;
                byte_valid = rx;
                frame_err  = !rx;
            end
            default:  rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st   <= RX_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            rx_st <= rx_nxt;
            if (rx_st == RX_IDLE || rx_nxt != rx_st || sample) cnt <= '0;
            else                                               cnt <= cnt + 1'b1;
            if (rx_st == RX_START) bit_cnt <= '0;
            if (rx_st == RX_DATA && sample) begin
                shreg   <= {rx, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    ld_state_t         st, st_nxt;
    logic [7:0]        len_lo;
    logic [15:0]       len_full;
    logic [CW-1:0]     rem;
    logic [ROM_AW+2:0] k;
    logic [7:0][7:0]   wbuf, word_in;
    logic              take_data, last;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign len_full = {shreg, len_lo};
    assign last     = (rem == CW'(1));

    always_comb begin
        word_in          = wbuf;
        word_in[k[2:0]]  = shreg;
    end

    always_comb begin
        st_nxt    = st;
        take_data = 1'b0;
        if (!en) begin
            st_nxt = LD_IDLE;
        end else begin
            case (st)
                LD_IDLE: st_nxt = LD_HDR;
                LD_HDR:  if (byte_valid && shreg == 8'hA5) st_nxt = LD_LEN0;
                LD_LEN0: if (byte_valid) st_nxt = LD_LEN1;
                LD_LEN1: if (byte_valid) begin
                    if ({16'd0, len_full} > MAX_LEN) st_nxt = LD_ERR;
                    else if (len_full == 16'd0)       st_nxt = AFTER_DATA;
                    else                              st_nxt = LD_DATA;
                end
                LD_DATA: if (byte_valid) begin
                    take_data = 1'b1;
                    if (last) st_nxt = AFTER_DATA;
                end
`ifdef LOADER_CHECKSUM_EN
                LD_CSUM: if (byte_valid) st_nxt = (shreg == csum) ? LD_DONE : LD_ERR;
`endif
                default: ;
            endcase
            if (frame_err && st != LD_IDLE && st != LD_DONE && st != LD_ERR) st_nxt = LD_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= LD_IDLE;
            len_lo      <= '0;
            rem         <= '0;
            k           <= '0;
            wbuf        <= '0;
            rom_we_o    <= 1'b0;
            rom_waddr_o <= '0;
            rom_wdata_o <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            st       <= st_nxt;
            rom_we_o <= 1'b0;
            if (st == LD_IDLE) begin
                len_lo <= '0;
                rem    <= '0;
                k      <= '0;
                wbuf   <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum   <= '0;
`endif
            end else if (en && byte_valid) begin
`ifdef LOADER_CHECKSUM_EN
                if (st == LD_LEN0 || st == LD_LEN1 || st == LD_DATA) csum <= csum + shreg;
`endif
                if (st == LD_LEN0) len_lo <= shreg;
                if (st == LD_LEN1) rem    <= CW'(len_full);
            end
            // a word goes out when lane 7 fills or the payload ends; the buffer restarts zeroed
            if (take_data) begin
                k   <= k + 1'b1;
                rem <= rem - 1'b1;
                if (k[2:0] == 3'd7 || last) begin
                    rom_we_o    <= 1'b1;
                    rom_wdata_o <= word_in;
                    rom_waddr_o <= k[ROM_AW+2:3];
                    wbuf        <= '0;
                end else begin
                    wbuf <= word_in;
                end
            end
        end
    end

    assign done_o     = en & (st == LD_DONE);
    assign err_o      = en & (st == LD_ERR);
    assign cpu_hold_o = en & (st != LD_DONE);
endmodule
